// File: rtl/pcie_scr_pkg.sv
// Shared constants and LFSR helpers for the Gen1/Gen2 PCIe byte scrambler.
// Polynomial x^16+x^5+x^4+x^3+1, Galois form, seeded with all ones.
// The scrambler serialises LSB first, so keystream bit i of a byte is bit 15
// of the state after i shifts.
package pcie_scr_pkg;

  localparam logic [7:0]  ComSym   = 8'hBC;  // K28.5
  localparam logic [7:0]  SkpSym   = 8'h1C;  // K28.0
  localparam logic [15:0] LfsrPoly = 16'h0039;  // x^5 + x^4 + x^3 + 1 taps
  localparam logic [15:0] LfsrSeed = 16'hFFFF;

  // State after eight serial shifts.
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] state);
    logic [15:0] s;
    s = state;
    for (int i = 0; i < 8; i++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? LfsrPoly : 16'h0000);
    end
    return s;
  endfunction

  // Eight keystream bits produced while advancing from the given state.
  function automatic logic [7:0] lfsr_key8(input logic [15:0] state);
    logic [15:0] s;
    logic [7:0]  key;
    s   = state;
    key = 8'h00;
    for (int i = 0; i < 8; i++) begin
      key[i] = s[15];
      s      = {s[14:0], 1'b0} ^ (s[15] ? LfsrPoly : 16'h0000);
    end
    return key;
  endfunction

endpackage

// File: rtl/scr_byte_step.sv
// Combinational single-symbol scrambler step.
// Ports:
//   state_i   - LFSR state seen by this symbol
//   byte_i    - input symbol
//   k_i       - K flag of the symbol
//   vld_i     - symbol is within the valid length of the word
//   scr_dis_i - suppress the data XOR (state still advances)
//   byte_o    - scrambled symbol (0 for invalid symbols)
//   state_o   - LFSR state handed to the next symbol
module scr_byte_step
  import pcie_scr_pkg::*;
#(
  parameter logic [7:0] COM_SYM = ComSym,
  parameter logic [7:0] SKP_SYM = SkpSym
) (
  input  logic [15:0] state_i,
  input  logic [7:0]  byte_i,
  input  logic        k_i,
  input  logic        vld_i,
  input  logic        scr_dis_i,
  output logic [7:0]  byte_o,
  output logic [15:0] state_o
);

  always_comb begin
    byte_o  = 8'h00;
    state_o = state_i;
    if (vld_i) begin
      if (k_i) begin
        byte_o = byte_i;
        if (byte_i == COM_SYM) begin
          state_o = LfsrSeed;
        end else if (byte_i == SKP_SYM) begin
          state_o = state_i;
        end else begin
          state_o = lfsr_adv8(state_i);
        end
      end else begin
        byte_o  = scr_dis_i ? byte_i : (byte_i ^ lfsr_key8(state_i));
        state_o = lfsr_adv8(state_i);
      end
    end
  end

endmodule

// File: rtl/pipe_scrambler_gen12.sv
// Parametrised Gen1/Gen2 PIPE transmit scrambler (also usable as descrambler).
// Ports:
//   clk_i            - clock, rising edge
//   rst_ni           - synchronous active-low reset
//   valid_i          - input word valid
//   indata_i         - BYTES symbols, byte 0 in [7:0] and first in time
//   datak_i          - per-byte K flags
//   data_len_i       - number of valid bytes minus one, packed from byte 0
//   scr_dis_i        - bypass the data XOR, LFSR still tracks
//   valid_o          - registered output valid
//   scrambled_data_o - registered scrambled symbols
//   datak_o          - registered K flags (masked to valid bytes)
//   data_len_o       - registered length
module pipe_scrambler_gen12
  import pcie_scr_pkg::*;
#(
  parameter int unsigned BYTES   = 4,
  parameter int unsigned LEN_W   = (BYTES > 1) ? $clog2(BYTES) : 1,
  parameter logic [7:0]  COM_SYM = ComSym,
  parameter logic [7:0]  SKP_SYM = SkpSym
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  input  logic [8*BYTES-1:0] indata_i,
  input  logic [BYTES-1:0]   datak_i,
  input  logic [LEN_W-1:0]   data_len_i,
  input  logic               scr_dis_i,
  output logic               valid_o,
  output logic [8*BYTES-1:0] scrambled_data_o,
  output logic [BYTES-1:0]   datak_o,
  output logic [LEN_W-1:0]   data_len_o
);

  logic [15:0]        lfsr_q, lfsr_d;
  logic               valid_q, valid_d;
  logic [8*BYTES-1:0] data_q, data_d;
  logic [BYTES-1:0]   datak_q, datak_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic [BYTES-1:0]   byte_vld;
  logic [8*BYTES-1:0] step_data;
  logic [15:0]        chain_end;

  always_comb begin
    byte_vld = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      byte_vld[i] = (i <= 32'(data_len_i));
    end
  end

  // Each stage sees the state left by the previous byte of the same word.
  for (genvar g = 0; g < BYTES; g++) begin : g_step
    logic [15:0] st_in;
    logic [15:0] st_out;

    if (g == 0) begin : g_first
      assign st_in = lfsr_q;
    end else begin : g_next
      assign st_in = g_step[g-1].st_out;
    end

    scr_byte_step #(
      .COM_SYM (COM_SYM),
      .SKP_SYM (SKP_SYM)
    ) u_step (
      .state_i   (st_in),
      .byte_i    (indata_i[8*g +: 8]),
      .k_i       (datak_i[g]),
      .vld_i     (byte_vld[g]),
      .scr_dis_i (scr_dis_i),
      .byte_o    (step_data[8*g +: 8]),
      .state_o   (st_out)
    );
  end

  assign chain_end = g_step[BYTES-1].st_out;

  always_comb begin
    valid_d = valid_i;
    data_d  = '0;
    datak_d = '0;
    len_d   = '0;
    lfsr_d  = lfsr_q;
    if (valid_i) begin
      data_d  = step_data;
      datak_d = datak_i & byte_vld;
      len_d   = data_len_i;
      lfsr_d  = chain_end;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q  <= LfsrSeed;
      valid_q <= 1'b0;
      data_q  <= '0;
      datak_q <= '0;
      len_q   <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      datak_q <= datak_d;
      len_q   <= len_d;
    end
  end

  assign valid_o          = valid_q;
  assign scrambled_data_o = data_q;
  assign datak_o          = datak_q;
  assign data_len_o       = len_q;

endmodule

// File: doc/pipe_scrambler_gen12.md
# pipe_scrambler_gen12

Parametrised Gen1/Gen2 (8b/10b-era) PCIe byte scrambler for the PIPE transmit path, successor to the fixed 32-bit scrambler top. It accepts up to `BYTES` symbols per cycle, each with a K flag, and applies the x^16+x^5+x^4+x^3+1 LFSR per PCIe Base Spec. COM resets the LFSR, SKP freezes it, and D symbols are scrambled. It adds a valid qualifier, a scramble-disable bypass, and a registered output stage. The XOR is symmetric, so the same block instantiated on the receive side is the descrambler.

## Interface
Parameters:
- `BYTES`, 4: symbols per cycle. Legal values are 1, 2, 4 and 8.
- `LEN_W`, `$clog2(BYTES)` (minimum 1): width of the length field.
- `COM_SYM`, 8'hBC: K28.5 value.
- `SKP_SYM`, 8'h1C: K28.0 value.

Ports:
- `clk_i`, in, 1: clock. All logic is on the rising edge.
- `rst_ni`, in, 1: synchronous, active-low reset.
- `valid_i`, in, 1: the input word is valid this cycle.
- `indata_i`, in, 8*BYTES: symbols. Byte 0 is `[7:0]` and is the first in time.
- `datak_i`, in, BYTES: per-byte K flag.
- `data_len_i`, in, LEN_W: number of valid bytes minus 1. Valid bytes are packed from byte 0.
- `scr_dis_i`, in, 1: scrambling disabled (TS "disable scrambling" bit). Data passes through unmodified.
- `valid_o`, out, 1: the output word is valid.
- `scrambled_data_o`, out, 8*BYTES: scrambled symbols.
- `datak_o`, out, BYTES: K flags, delayed to align with the data.
- `data_len_o`, out, LEN_W: length, delayed to align with the data.

## Operation
- LFSR state is 16 bits. The reset value is 16'hFFFF.
- A word is processed only when `valid_i`=1. Bytes are handled in order 0..`data_len_i`, and each byte sees the LFSR state left by the previous byte in the same word.
- Per-byte rules for a valid byte, given current state S:
  - K=1 and byte==`COM_SYM`: output the byte unscrambled. The next state is 16'hFFFF.
  - K=1 and byte==`SKP_SYM`: output the byte unscrambled. The next state is S (no advance).
  - Any other K=1 byte: output the byte unscrambled. The next state is S advanced 8 shifts.
  - K=0: output = byte XOR the 8 keystream bits from S (serial Galois LFSR, LSB of the byte first, per Base Spec Appendix C). The next state is S advanced 8 shifts.
- With `scr_dis_i`=1 the K=0 XOR is suppressed, but all state transitions above still apply. The LFSR therefore stays aligned when scrambling is re-enabled.
- Bytes beyond `data_len_i` are invalid:
  - They have no effect on the LFSR.
  - Their output byte is 8'h00 and their `datak_o` bit is 0.
- With `valid_i`=0 the LFSR holds, `valid_o` goes to 0 next cycle, and the data, K and length outputs drive 0.
- Multiple COM and/or SKP bytes in one word are legal and each is applied in byte order. Example: byte0=COM, byte2=COM leaves the state at FFFF+1 byte advance if byte3 is D.

## Timing
- Latency is exactly 1 cycle: input sampled at edge N appears on the outputs after edge N.
- Throughput is one word per cycle with no backpressure.
- Reset values: `valid_o`=0, `scrambled_data_o`=0, `datak_o`=0, `data_len_o`=0, LFSR=16'hFFFF.
- Reset asserted mid-stream: on the next edge all outputs go to 0 and the LFSR goes to FFFF. This happens regardless of `valid_i`, and the input word sampled on that edge is dropped.
- The entire per-word chain of up to `BYTES` byte steps is combinational within one cycle. The LFSR register updates on the same edge as the output register.

## Structure
- Shared package `pcie_scr_pkg` holds:
  - the `COM_SYM` and `SKP_SYM` defaults;
  - the LFSR polynomial and seed constant (16'hFFFF);
  - the function `lfsr_adv8(state)` returning the next state;
  - the function `lfsr_key8(state)` returning the keystream byte.
- One sub-module, `scr_byte_step`, is purely combinational.
  - Inputs: state, byte, K, valid, `scr_dis`. Outputs: byte out, next state.
  - The top instantiates `BYTES` copies in a generate chain, followed by the output and LFSR registers.

## Test plan
- **Reset then COM:** `valid_i`=1, `data_len_i`=BYTES-1, BYTES=4.
  - Word 0 = BC,00,00,00 with K=0001 gives output BC,FF,17,C0.
  - The next word 00,00,00,00 gives 14,B2,E7,02.
- **SKP freeze:** COM, then 00,1C(K),00.
  - Output is FF,1C,17. The SKP byte does not consume keystream.
- **Partial words / idle cycles:** BYTES=4, a COM word with `data_len_i`=1 (BC,00), then a `valid_i`=0 cycle, then 00 ×4.
  - Outputs: BC,FF,00,00 with `data_len_o`=1; then `valid_o`=0; then 17,C0,14,B2.
- **Disable bypass:** same stimulus as the first scenario with `scr_dis_i`=1 on word 0 only.
  - Word 0 output is BC,00,00,00. Word 1 output is still 14,B2,E7,02.
- **Mid-stream reset:** after 3 data words, pull `rst_ni` low for one cycle.
  - Outputs are 0 and `valid_o`=0. The next COM+00 word restarts at FF,17,C0.
- **Parameter sweep and loopback:** BYTES=1, 2 and 8 carrying the same byte stream produce identical serialized output.
  - A second instance in descramble mode looped back recovers the original data.
